program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Loads a program into a local instruction store and sequences the 8-bit single-cycle core.
//  Instructions are indexed by the core's pc. Provides run, pause and single-step modes.
//  Issues a core reset pulse and a per-instruction clock enable, and halts when pc leaves
//  the loaded program. Sits between the board switches/loader and the core's instruction
//  input and clock enable.
// PARAMETERS
//  ADDR_W     4   instruction-store address width; DEPTH = 2**ADDR_W words of 8 bits
// PORTS
//  clk          in   1         system clock; all state changes on posedge
//  reset        in   1         asynchronous, active-low; 0 clears all state immediately
//  load_valid   in   1         loader presents load_data
//  load_ready   out  1         sequencer accepts a word this cycle
//  load_data    in   8         instruction word to store
//  load_last    in   1         qualifies load_data as the final program word
//  start        in   1         level; begin/resume free-running execution
//  step         in   1         level; each 0->1 edge executes exactly one instruction
//  stop         in   1         level; pause execution
//  core_pc      in   8         current pc from the core
//  instruction  out  8         word fed to core: mem[core_pc[ADDR_W-1:0]], combinational
//  core_en      out  1         core clock enable; one instruction retires per high cycle
//  core_rst     out  1         active-high reset pulse to the core
//  prog_len     out  ADDR_W+1  number of words loaded (0..DEPTH)
//  done         out  1         high in HALT
//  state        out  3         encoded FSM state, for display
// BEHAVIOUR
//  Reset (reset=0):
//   state=IDLE, prog_len=0, write pointer=0, step edge register=0.
//   Outputs: load_ready=1, core_en=0, core_rst=0, done=0. Store contents are not cleared.
//  States:
//   IDLE=0, LOADED=1, PRIME=2, RUN=3, PAUSE=4, HALT=5. Codes 6 and 7 are illegal and go to IDLE.
//  Load handshake: a word transfers when load_valid&load_ready at posedge.
//   - load_ready=1 only in IDLE.
//   - The word is written to mem[wr_ptr], and wr_ptr and prog_len both increment.
//   - load_last=1, or wr_ptr==DEPTH-1, ends the load: IDLE->LOADED, load_ready drops the next cycle.
//   - load_valid with load_ready=0 is ignored; no word is written.
//  LOADED/PAUSE/HALT + start=1 (and stop=0) -> PRIME:
//   core_rst=1 for exactly one cycle, core_en=0. From PAUSE, go to RUN directly instead (no reset).
//  PRIME -> RUN unconditionally.
//  RUN:
//   - core_en = (core_pc < prog_len), combinational.
//   - When core_pc >= prog_len (this includes a branch wrap to a large pc): core_en=0 that
//     cycle, go to HALT next cycle, done=1.
//   - stop=1 -> PAUSE next cycle. core_en stays high in the cycle stop is sampled.
//  PAUSE:
//   - core_en=0 except in the cycle after a step 0->1 edge: one-cycle core_en, only if
//     core_pc < prog_len. Otherwise go to HALT.
//   - Step edge detection is registered: an edge at cycle n gives core_en at cycle n+1.
//  Step from LOADED or HALT: PRIME, then PAUSE; the step itself is not executed.
//  HALT: core_en=0 and done=1. start restarts via PRIME; stop has no effect.
//  Priority when signals coincide: stop > start > step. An empty program (prog_len=0) makes
//   start go PRIME->RUN->HALT with no core_en cycle.
//  Reload: IDLE is re-entered only by reset.
//  Reset mid-RUN: core_en drops asynchronously in the same cycle reset falls. Any word
//   already loaded is kept in the store but is unreachable because prog_len=0.
//  Width rule: compare core_pc zero-extended against prog_len. core_pc bits above ADDR_W
//   that are nonzero count as out of range.
// TESTING
//  1. Load 3 words A0,B1,C2 (last on C2), load_valid held high -> accepted on 3 consecutive
//     cycles, prog_len=3, state=LOADED, load_ready=0.
//  2. start with core_pc model counting 0,1,2,3 -> 1-cycle core_rst, then core_en high 3
//     cycles, instruction=A0,B1,C2, then done=1.
//  3. RUN, assert stop at pc=1 -> PAUSE. Two step edges -> exactly two single core_en
//     pulses, each one cycle after its edge.
//  4. Load DEPTH words with no load_last -> auto-LOADED at word 16 (ADDR_W=4), prog_len=16,
//     17th load_valid not accepted.
//  5. core_pc jumps to 8'hFE in RUN -> core_en=0 that cycle, HALT next cycle.
//     start -> PRIME and the program restarts.
//  6. reset=0 mid-RUN -> core_en=0 immediately, state=IDLE, prog_len=0. Same-cycle start+stop
//     in PAUSE -> stays PAUSE.

Source files
------------

// File: rtl/program_sequencer.sv
// Instruction store and run/pause/step sequencer for the 8-bit single-cycle core.
// Loads a program over a valid/ready port, then gates the core with a reset pulse and clock enable.
module program_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              step,
    input  logic              stop,
    input  logic [7:0]        core_pc,
    output logic [7:0]        instruction,
    output logic              core_en,
    output logic              core_rst,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic [2:0]        state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CMP_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_PRIME  = 3'd2,
        ST_RUN    = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   prog_len_r;
    logic              step_d_r;
    logic              step_pulse_r;
    logic              prime_to_pause_r;
    logic              prime_to_pause_next_s;
    logic              load_fire_s;
    logic              load_end_s;
    logic              in_range_s;
    logic [7:0]        mem_r [DEPTH];

    // Upper pc bits take part in the compare so a wrapped/branched pc counts as out of range.
    assign in_range_s  = CMP_W'(core_pc) < CMP_W'(prog_len_r);
    assign load_fire_s = (state_r == ST_IDLE) && load_valid;
    assign load_end_s  = load_last || (wr_ptr_r == ADDR_W'(DEPTH - 1));
    assign instruction = mem_r[core_pc[ADDR_W-1:0]];
    assign prog_len    = prog_len_r;
    assign state       = state_r;

    // Instruction store write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            mem_r[wr_ptr_r] <= load_data;
        end
    end

    // State, load pointer/length and step edge registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            wr_ptr_r         <= '0;
            prog_len_r       <= '0;
            step_d_r         <= 1'b0;
            step_pulse_r     <= 1'b0;
            prime_to_pause_r <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            step_d_r         <= step;
            step_pulse_r     <= step && !step_d_r;
            prime_to_pause_r <= prime_to_pause_next_s;
            if (load_fire_s) begin
                wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
                prog_len_r <= prog_len_r + (ADDR_W + 1)'(1);
            end
        end
    end

    // Next-state and output decode; stop outranks start, which outranks step.
    always_comb begin
        state_next_s          = state_r;
        prime_to_pause_next_s = prime_to_pause_r;
        load_ready            = 1'b0;
        core_en               = 1'b0;
        core_rst              = 1'b0;
        done                  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid && load_end_s) begin
                    state_next_s = ST_LOADED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOADED, ST_HALT: begin
                done = (state_r == ST_HALT);
                if (stop) begin
                    state_next_s = state_r;
                end else if (start) begin
                    state_next_s          = ST_PRIME;
                    prime_to_pause_next_s = 1'b0;
                end else if (step_pulse_r) begin
                    state_next_s          = ST_PRIME;
                    prime_to_pause_next_s = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_PRIME: begin
                core_rst = 1'b1;
                if (prime_to_pause_r) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RUN: begin
                core_en = in_range_s;
                if (stop) begin
                    state_next_s = ST_PAUSE;
                end else if (!in_range_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_next_s = ST_PAUSE;
                end else if (start) begin
                    state_next_s = ST_RUN;
                end else if (step_pulse_r) begin
                    if (in_range_s) begin
                        core_en      = 1'b1;
                        state_next_s = ST_PAUSE;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with a small counting-pc core model.
module tb_program_sequencer;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_last;
    logic       start;
    logic       step;
    logic       stop;
    logic [7:0] core_pc;
    logic [7:0] instruction;
    logic       core_en;
    logic       core_rst;
    logic [4:0] prog_len;
    logic       done;
    logic [2:0] state;

    logic       pc_load;
    logic [7:0] pc_val;
    int         errors;
    int         checks;

    program_sequencer #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .start(start), .step(step),
        .stop(stop), .core_pc(core_pc), .instruction(instruction), .core_en(core_en),
        .core_rst(core_rst), .prog_len(prog_len), .done(done), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: pc resets on core_rst, can be forced, otherwise advances per enabled cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) core_pc <= 8'h00;
        else if (core_rst) core_pc <= 8'h00;
        else if (pc_load) core_pc <= pc_val;
        else if (core_en) core_pc <= core_pc + 8'h01;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        start = 1'b0; step = 1'b0; stop = 1'b0; pc_load = 1'b0; pc_val = 8'h00;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_core_en", 32'(core_en), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        reset = 1'b1;

        // 1: three-word load with load_valid held
        tick();
        load_valid = 1'b1; load_data = 8'hA0;
        tick();
        chk("ld1_len", 32'(prog_len), 32'd1);
        load_data = 8'hB1;
        tick();
        chk("ld2_len", 32'(prog_len), 32'd2);
        load_data = 8'hC2; load_last = 1'b1;
        tick();
        chk("ld3_len", 32'(prog_len), 32'd3);
        chk("ld3_state", 32'(state), 32'd1);
        chk("ld3_ready", 32'(load_ready), 32'd0);
        chk("ld3_instr0", 32'(instruction), 32'hA0);
        load_valid = 1'b0; load_last = 1'b0; load_data = 8'h55;
        tick();
        chk("ld_ignored_len", 32'(prog_len), 32'd3);

        // 2: run to completion
        start = 1'b1;
        tick();
        chk("run_prime_state", 32'(state), 32'd2);
        chk("run_core_rst", 32'(core_rst), 32'd1);
        chk("run_prime_en", 32'(core_en), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run_state", 32'(state), 32'd3);
            chk("run_core_rst_low", 32'(core_rst), 32'd0);
            chk("run_en", 32'(core_en), 32'd1);
            chk("run_pc", 32'(core_pc), 32'(i));
            case (i)
                0: chk("run_instr", 32'(instruction), 32'hA0);
                1: chk("run_instr", 32'(instruction), 32'hB1);
                default: chk("run_instr", 32'(instruction), 32'hC2);
            endcase
        end
        tick();
        chk("run_end_en", 32'(core_en), 32'd0);
        chk("run_end_done", 32'(done), 32'd0);
        tick();
        chk("halt_state", 32'(state), 32'd5);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_en", 32'(core_en), 32'd0);

        // 3: restart, stop at pc=1, then single steps
        start = 1'b1;
        tick();
        chk("re_core_rst", 32'(core_rst), 32'd1);
        start = 1'b0;
        tick();
        chk("re_pc0_en", 32'(core_en), 32'd1);
        stop = 1'b1;
        tick();
        chk("pause_state", 32'(state), 32'd4);
        chk("pause_pc", 32'(core_pc), 32'd1);
        chk("pause_en", 32'(core_en), 32'd0);
        stop = 1'b0; step = 1'b1;
        tick();
        chk("step1_en", 32'(core_en), 32'd1);
        step = 1'b0;
        tick();
        chk("step1_gap", 32'(core_en), 32'd0);
        chk("step1_pc", 32'(core_pc), 32'd2);
        step = 1'b1;
        tick();
        chk("step2_en", 32'(core_en), 32'd1);
        step = 1'b0;
        tick();
        chk("step2_gap", 32'(core_en), 32'd0);
        chk("step2_state", 32'(state), 32'd4);
        start = 1'b1; stop = 1'b1;
        tick();
        chk("startstop_pause", 32'(state), 32'd4);
        start = 1'b0; stop = 1'b0; step = 1'b1;
        tick();
        chk("step_oor_en", 32'(core_en), 32'd0);
        step = 1'b0;
        tick();
        chk("step_oor_halt", 32'(state), 32'd5);

        // 5: branch to a large pc halts, start restarts
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("jmp_pc0_en", 32'(core_en), 32'd1);
        pc_load = 1'b1; pc_val = 8'hFE;
        tick();
        pc_load = 1'b0;
        chk("jmp_fe_en", 32'(core_en), 32'd0);
        chk("jmp_fe_state", 32'(state), 32'd3);
        tick();
        chk("jmp_halt", 32'(state), 32'd5);
        start = 1'b1;
        tick();
        chk("jmp_prime", 32'(state), 32'd2);
        chk("jmp_core_rst", 32'(core_rst), 32'd1);
        start = 1'b0;
        tick();
        chk("jmp_rerun_en", 32'(core_en), 32'd1);
        chk("jmp_rerun_instr", 32'(instruction), 32'hA0);

        // 6: asynchronous reset mid-run
        #2 reset = 1'b0;
        #1;
        chk("areset_en", 32'(core_en), 32'd0);
        chk("areset_state", 32'(state), 32'd0);
        chk("areset_len", 32'(prog_len), 32'd0);
        chk("areset_ready", 32'(load_ready), 32'd1);
        tick();
        reset = 1'b1;

        // 4: full-depth load with no load_last
        tick();
        load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_data = 8'h10 + 8'(i);
            tick();
        end
        chk("full_state", 32'(state), 32'd1);
        chk("full_len", 32'(prog_len), 32'd16);
        chk("full_ready", 32'(load_ready), 32'd0);
        load_data = 8'hEE;
        tick();
        load_valid = 1'b0;
        chk("full_17_len", 32'(prog_len), 32'd16);
        chk("full_17_mem0", 32'(instruction), 32'h10);
        pc_load = 1'b1; pc_val = 8'h0F;
        tick();
        pc_load = 1'b0;
        chk("full_mem15", 32'(instruction), 32'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
